// File: rtl/rv32i_hazard_unit.sv
// rtl/rv32i_hazard_unit.sv - RAW hazard scoreboard with stall/forward selection for an in-order RV32I pipeline
module rv32i_hazard_unit #(
  parameter int DEPTH      = 3,
  parameter int FORWARD_EN = 0,
  parameter int LOAD_LAT   = 2,
  parameter int CNT_W      = 16,
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             dec_valid_i,
  input  logic [4:0]       dec_rs1_i,
  input  logic [4:0]       dec_rs2_i,
  input  logic             dec_uses_rs1_i,
  input  logic             dec_uses_rs2_i,
  input  logic [4:0]       dec_rd_i,
  input  logic             dec_writes_rd_i,
  input  logic             dec_is_load_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             issue_o,
  output logic [SW-1:0]    fwd_rs1_sel_o,
  output logic [SW-1:0]    fwd_rs2_sel_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  logic [DEPTH:1] sb_v;
  logic [DEPTH:1] sb_ld;
  logic [4:0]     sb_rd [1:DEPTH];

  logic [SW-1:0]  win1, win2;
  logic           lu1, lu2;
  logic           hz1, hz2;

  // Scan oldest to youngest so the smallest matching stage is the one kept.
  always_comb begin
    win1 = '0;
    win2 = '0;
    lu1  = 1'b0;
    lu2  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (sb_v[k] && sb_rd[k] == dec_rs1_i) begin
        win1 = SW'(k);
        lu1  = sb_ld[k] && (k < LOAD_LAT);
      end
      if (sb_v[k] && sb_rd[k] == dec_rs2_i) begin
        win2 = SW'(k);
        lu2  = sb_ld[k] && (k < LOAD_LAT);
      end
    end
    hz1 = dec_uses_rs1_i && (dec_rs1_i != 5'd0) && (win1 != '0);
    hz2 = dec_uses_rs2_i && (dec_rs2_i != 5'd0) && (win2 != '0);
  end

  always_comb begin
    stall_o       = 1'b0;
    issue_o       = 1'b0;
    fwd_rs1_sel_o = '0;
    fwd_rs2_sel_o = '0;
    if (resetn_i) begin
      if (FORWARD_EN != 0) begin
        stall_o       = dec_valid_i && !flush_i && ((hz1 && lu1) || (hz2 && lu2));
        fwd_rs1_sel_o = hz1 ? win1 : '0;
        fwd_rs2_sel_o = hz2 ? win2 : '0;
      end else begin
        stall_o = dec_valid_i && !flush_i && (hz1 || hz2);
      end
      issue_o = dec_valid_i && !stall_o && !flush_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      sb_v        <= '0;
      sb_ld       <= '0;
      stall_cnt_o <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        sb_rd[k] <= 5'd0;
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        sb_v[k]  <= sb_v[k-1];
        sb_ld[k] <= sb_ld[k-1];
        sb_rd[k] <= sb_rd[k-1];
      end
      // x0 writes never create a producer entry.
      sb_v[1]  <= issue_o && dec_writes_rd_i && (dec_rd_i != 5'd0);
      sb_ld[1] <= issue_o && dec_is_load_i;
      sb_rd[1] <= issue_o ? dec_rd_i : 5'd0;
      if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
        stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// tb/tb_rv32i_hazard_unit.sv - checks a stall-only and a forwarding hazard unit against an issue-history model
module tb_rv32i_hazard_unit;

  logic       clk = 1'b0;
  logic       resetn;
  logic       valid, u1, u2, wr, ld, flush;
  logic [4:0] rs1, rs2, rd;

  logic        stall_a, issue_a, stall_b, issue_b;
  logic [1:0]  f1_a, f2_a, f1_b, f2_b;
  logic [1:0]  cnt_a;
  logic [15:0] cnt_b;

  always #5 clk = ~clk;

  rv32i_hazard_unit #(.DEPTH(3), .FORWARD_EN(0), .LOAD_LAT(2), .CNT_W(2)) dut_a (
    .clk_i(clk), .resetn_i(resetn), .dec_valid_i(valid),
    .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2),
    .dec_rd_i(rd), .dec_writes_rd_i(wr), .dec_is_load_i(ld), .flush_i(flush),
    .stall_o(stall_a), .issue_o(issue_a), .fwd_rs1_sel_o(f1_a), .fwd_rs2_sel_o(f2_a),
    .stall_cnt_o(cnt_a)
  );

  rv32i_hazard_unit #(.DEPTH(3), .FORWARD_EN(1), .LOAD_LAT(2), .CNT_W(16)) dut_b (
    .clk_i(clk), .resetn_i(resetn), .dec_valid_i(valid),
    .dec_rs1_i(rs1), .dec_rs2_i(rs2), .dec_uses_rs1_i(u1), .dec_uses_rs2_i(u2),
    .dec_rd_i(rd), .dec_writes_rd_i(wr), .dec_is_load_i(ld), .flush_i(flush),
    .stall_o(stall_b), .issue_o(issue_b), .fwd_rs1_sel_o(f1_b), .fwd_rs2_sel_o(f2_b),
    .stall_cnt_o(cnt_b)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // History model: the producer in stage k is whatever issued k cycles ago.
  bit         hv  [2][0:8191];
  bit         hld [2][0:8191];
  logic [4:0] hrd [2][0:8191];
  int         cyc = 16;
  int         mcnt [2];
  int         cmax [2];
  bit         e_stall [2];
  bit         e_issue [2];
  int         e_f1 [2];
  int         e_f2 [2];

  int o_stall_a, o_issue_a, o_f1_a, o_f2_a;
  int o_stall_b, o_issue_b, o_f1_b, o_f2_b;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int find(input int d, input logic [4:0] rs);
    for (int k = 1; k <= 3; k++) begin
      if (hv[d][cyc-k] && hrd[d][cyc-k] == rs) return k;
    end
    return 0;
  endfunction

  task automatic model_comb(input int d);
    int  w1, w2;
    bit  lu;
    w1 = (u1 && rs1 != 5'd0) ? find(d, rs1) : 0;
    w2 = (u2 && rs2 != 5'd0) ? find(d, rs2) : 0;
    lu = (w1 != 0 && hld[d][cyc-w1] && w1 < 2) || (w2 != 0 && hld[d][cyc-w2] && w2 < 2);
    if (!resetn || flush || !valid) e_stall[d] = 1'b0;
    else if (d == 1)                e_stall[d] = lu;
    else                            e_stall[d] = (w1 != 0) || (w2 != 0);
    e_issue[d] = resetn && valid && !e_stall[d] && !flush;
    e_f1[d] = (d == 1 && resetn) ? w1 : 0;
    e_f2[d] = (d == 1 && resetn) ? w2 : 0;
  endtask

  task automatic model_edge(input int d);
    if (!resetn) begin
      for (int j = 0; j <= 6; j++) hv[d][cyc-j] = 1'b0;
      mcnt[d] = 0;
    end else begin
      hv[d][cyc]  = e_issue[d] && wr && rd != 5'd0;
      hrd[d][cyc] = rd;
      hld[d][cyc] = ld;
      if (e_stall[d] && mcnt[d] < cmax[d]) mcnt[d]++;
    end
  endtask

  task automatic setin(input bit v, input int a, input bit ua, input int b, input bit ub,
                       input int d, input bit w, input bit l, input bit f);
    valid = v; rs1 = 5'(a); u1 = ua; rs2 = 5'(b); u2 = ub;
    rd = 5'(d); wr = w; ld = l; flush = f;
  endtask

  task automatic tick();
    #1;
    model_comb(0);
    model_comb(1);
    o_stall_a = int'(stall_a); o_issue_a = int'(issue_a); o_f1_a = int'(f1_a); o_f2_a = int'(f2_a);
    o_stall_b = int'(stall_b); o_issue_b = int'(issue_b); o_f1_b = int'(f1_b); o_f2_b = int'(f2_b);
    chk("a_stall", o_stall_a, int'(e_stall[0]));
    chk("a_issue", o_issue_a, int'(e_issue[0]));
    chk("a_fwd1", o_f1_a, e_f1[0]);
    chk("a_fwd2", o_f2_a, e_f2[0]);
    chk("b_stall", o_stall_b, int'(e_stall[1]));
    chk("b_issue", o_issue_b, int'(e_issue[1]));
    chk("b_fwd1", o_f1_b, e_f1[1]);
    chk("b_fwd2", o_f2_b, e_f2[1]);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    cyc++;
    #1;
    chk("a_cnt", int'(cnt_a), mcnt[0]);
    chk("b_cnt", int'(cnt_b), mcnt[1]);
    @(negedge clk);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin
    cmax[0] = 3;
    cmax[1] = 65535;
    mcnt[0] = 0;
    mcnt[1] = 0;
    resetn = 1'b0;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    tick();
    chk("reset_cnt_a", int'(cnt_a), 0);
    chk("reset_stall_a", o_stall_a, 0);
    resetn = 1'b1;

    // addi x5 then add x6,x5,x5
    setin(1, 0, 1, 0, 0, 5, 1, 0, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      setin(1, 5, 1, 5, 1, 6, 1, 0, 0);
      tick();
      chk("raw_stall_a", o_stall_a, (i < 3) ? 1 : 0);
      chk("raw_issue_a", o_issue_a, (i == 3) ? 1 : 0);
      if (i < 3) chk("sat_seq_a", int'(cnt_a), i + 1);
      if (i == 0) begin
        chk("fwd_stall_b", o_stall_b, 0);
        chk("fwd1_b", o_f1_b, 1);
        chk("fwd2_b", o_f2_b, 1);
      end
    end
    chk("raw_cnt_a", int'(cnt_a), 3);

    // consumer of x6 keeps stalling: counter holds at 3, then reset mid-stall
    for (int i = 0; i < 2; i++) begin
      setin(1, 6, 1, 0, 0, 7, 1, 0, 0);
      tick();
      chk("sat_stall_a", o_stall_a, 1);
      chk("sat_hold_a", int'(cnt_a), 3);
    end
    resetn = 1'b0;
    tick();
    chk("rst_stall_a", o_stall_a, 0);
    chk("rst_issue_a", o_issue_a, 0);
    chk("rst_fwd1_b", o_f1_b, 0);
    chk("rst_issue_b", o_issue_b, 0);
    chk("rst_cnt_a", int'(cnt_a), 0);
    resetn = 1'b1;
    tick();
    chk("post_rst_stall_a", o_stall_a, 0);
    chk("post_rst_issue_a", o_issue_a, 1);

    // lw x7 then add x8,x7,x0
    nops(3);
    setin(1, 0, 1, 0, 0, 7, 1, 1, 0);
    tick();
    setin(1, 7, 1, 0, 1, 8, 1, 0, 0);
    tick();
    chk("lu_stall_b", o_stall_b, 1);
    tick();
    chk("lu_release_b", o_stall_b, 0);
    chk("lu_fwd1_b", o_f1_b, 2);
    chk("lu_issue_b", o_issue_b, 1);

    // two producers of x5: youngest wins; x0 reader never hazards
    nops(3);
    setin(1, 0, 1, 0, 0, 5, 1, 0, 0);
    tick();
    tick();
    setin(1, 5, 1, 0, 1, 9, 1, 0, 0);
    tick();
    chk("young_fwd1_b", o_f1_b, 1);
    chk("young_fwd2_b", o_f2_b, 0);
    setin(1, 0, 1, 0, 1, 10, 1, 0, 0);
    tick();
    chk("x0_stall_a", o_stall_a, 0);
    chk("x0_fwd1_b", o_f1_b, 0);

    // flush on a hazarded decode inserts a bubble into stage 1
    nops(3);
    setin(1, 0, 1, 0, 0, 9, 1, 1, 0);
    tick();
    setin(1, 9, 1, 0, 0, 9, 1, 0, 1);
    tick();
    chk("flush_stall_b", o_stall_b, 0);
    chk("flush_issue_b", o_issue_b, 0);
    chk("flush_issue_a", o_issue_a, 0);
    setin(1, 9, 1, 0, 0, 11, 1, 0, 0);
    tick();
    chk("flush_bubble_b", o_f1_b, 2);

    for (int i = 0; i < 1500; i++) begin
      resetn = ($urandom_range(0, 49) != 0);
      setin($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 7),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
